// File: rtl/cache_ctrl.sv
// cache_ctrl: write-back, write-allocate direct-mapped cache controller
// between the CPU load/store port and the DDR2 line interface.
module cache_ctrl #(
    parameter int INDEX_BITS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [26:0]  req_addr,
    input  logic [31:0]  req_wdata,
    output logic         resp_valid,
    output logic [31:0]  resp_rdata,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic         mem_write,
    output logic [26:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic         mem_rdata_valid,
    input  logic [127:0] mem_rdata
);

    localparam int ADDR_BITS = 27;
    localparam int TAG_BITS  = ADDR_BITS - INDEX_BITS - 4;
    localparam int LINES     = 1 << INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        FILL_REQ,
        FILL_WAIT,
        REFILL,
        RESP
    } state_t;

    state_t state, state_nx;

    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [127:0]        data_mem [LINES];
    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [1:0]            req_word;
    logic                  req_wr;
    logic [31:0]           req_wd;

    logic [TAG_BITS-1:0] rd_tag;
    logic [127:0]        rd_line;
    logic                rd_valid;
    logic                rd_dirty;
    logic [127:0]        fill_line;
    logic [31:0]         resp_word;

    logic [TAG_BITS-1:0]   in_tag;
    logic [INDEX_BITS-1:0] in_idx;
    logic                  accept;
    logic                  hit;
    logic                  wr_hit;
    logic [127:0]          hit_line;
    logic [127:0]          refill_line;

    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    function automatic logic [31:0] get_word(
        input logic [127:0] line,
        input logic [1:0]   w
    );
        return line[{w, 5'b0} +: 32];
    endfunction

    function automatic logic [127:0] put_word(
        input logic [127:0] line,
        input logic [1:0]   w,
        input logic [31:0]  d
    );
        logic [127:0] l;
        l = line;
        l[{w, 5'b0} +: 32] = d;
        return l;
    endfunction

    assign in_tag = req_addr[ADDR_BITS-1:INDEX_BITS+4];
    assign in_idx = req_addr[INDEX_BITS+3:4];
    assign accept = req_valid && (state == IDLE);

    assign hit      = rd_valid && (rd_tag == req_tag);
    assign wr_hit   = (state == LOOKUP) && hit && req_wr;
    assign hit_line = put_word(rd_line, req_word, req_wd);

    // A store miss merges its word into the incoming line before the write.
    assign refill_line = req_wr ? put_word(fill_line, req_word, req_wd)
                                : fill_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            rd_valid <= 1'b0;
            rd_dirty <= 1'b0;
            req_tag  <= '0;
            req_idx  <= '0;
            req_word <= '0;
            req_wr   <= 1'b0;
            req_wd   <= '0;
            resp_word <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                req_tag  <= in_tag;
                req_idx  <= in_idx;
                req_word <= req_addr[3:2];
                req_wr   <= req_write;
                req_wd   <= req_wdata;
                rd_valid <= valid_q[in_idx];
                rd_dirty <= dirty_q[in_idx];
            end
            if (state == LOOKUP && hit) begin
                resp_word <= req_wr ? req_wd
                                    : get_word(rd_line, req_word);
            end
            if (wr_hit) begin
                dirty_q[req_idx] <= 1'b1;
            end
            if (state == REFILL) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= req_wr;
                resp_word <= req_wr ? req_wd
                                    : get_word(fill_line, req_word);
            end
        end
    end

    // Tag and data storage carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_tag  <= tag_mem[in_idx];
            rd_line <= data_mem[in_idx];
        end
        if (state == FILL_WAIT && mem_rdata_valid) begin
            fill_line <= mem_rdata;
        end
        if (wr_hit) begin
            data_mem[req_idx] <= hit_line;
        end
        if (state == REFILL) begin
            data_mem[req_idx] <= refill_line;
            tag_mem[req_idx]  <= req_tag;
        end
    end

    always_comb begin
        state_nx      = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        mem_req_valid = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    state_nx = RESP;
                end else if (rd_valid && rd_dirty) begin
                    state_nx = WB_REQ;
                end else begin
                    state_nx = FILL_REQ;
                end
            end
            WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_write     = 1'b1;
                mem_addr      = {rd_tag, req_idx, 4'b0};
                mem_wdata     = rd_line;
                if (mem_req_ready) begin
                    state_nx = FILL_REQ;
                end
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = {req_tag, req_idx, 4'b0};
                if (mem_req_ready) begin
                    state_nx = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (mem_rdata_valid) begin
                    state_nx = REFILL;
                end
            end
            REFILL: begin
                state_nx = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = resp_word;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: vector table with a small memory
// responder, plus backpressure and mid-fill reset sequences.
module tb_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [26:0]  req_addr;
    logic [31:0]  req_wdata;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_write;
    logic [26:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_rdata_valid;
    logic [127:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_ctrl #(.INDEX_BITS(10)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata       (mem_rdata)
    );

    typedef struct {
        logic         wr;
        logic [26:0]  addr;
        logic [31:0]  wdata;
        logic [127:0] fill;
        logic         exp_wb;
        logic [26:0]  wb_addr;
        logic [127:0] wb_data;
        logic         exp_fill;
        logic [26:0]  fill_addr;
        logic [31:0]  rdata;
    } vec_t;

    localparam logic [127:0] L1 = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    localparam logic [127:0] L1W = {32'h0, 32'h0, 32'hDEADBEEF, 32'h12345678};
    localparam logic [127:0] L2 = {32'hA3A3A3A3, 32'hA2A2A2A2,
                                   32'hA1A1A1A1, 32'hA0A0A0A0};
    localparam logic [127:0] L2W = {32'hA3A3A3A3, 32'h55AA55AA,
                                    32'hA1A1A1A1, 32'hA0A0A0A0};
    localparam logic [127:0] L3 = {32'h30000003, 32'h30000002,
                                   32'h30000001, 32'h30000000};
    localparam logic [127:0] L3W = {32'h30000003, 32'h30000002,
                                    32'hCAFEF00D, 32'h30000000};
    localparam logic [127:0] L4 = {32'hC0000003, 32'hC0000002,
                                   32'hC0000001, 32'hC0000000};
    localparam logic [127:0] L5 = {32'h44444444, 32'h33333333,
                                   32'h22222222, 32'h11111111};
    localparam logic [127:0] L6 = {32'h0, 32'h0, 32'h0, 32'h0BADF00D};
    localparam logic [127:0] L7 = {32'h0, 32'h0, 32'h0, 32'h7777AAAA};

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drives one request and plays the memory side with zero-wait handshakes.
    task automatic run_vec(input vec_t v, input string id);
        int n;
        int rv_n;
        int nwb;
        int nfill;
        bit pend;
        bit done;
        n = 0; rv_n = -100; nwb = 0; nfill = 0; pend = 0; done = 0;
        chk({id, "_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(negedge clk);
        n = 1;
        req_valid = 1'b0;
        while (!done && n < 60) begin
            mem_req_ready   = 1'b0;
            mem_rdata_valid = 1'b0;
            if (resp_valid) begin
                done = 1;
                chk({id, "_rdata"}, resp_rdata, v.rdata);
                chk({id, "_latency"}, n, v.exp_fill ? rv_n + 2 : 2);
            end else if (mem_req_valid) begin
                mem_req_ready = 1'b1;
                if (mem_write) begin
                    nwb++;
                    chk({id, "_wb_addr"}, mem_addr, v.wb_addr);
                    chk({id, "_wb_data"}, mem_wdata, v.wb_data);
                    chk({id, "_wb_before_fill"}, nfill, 0);
                end else begin
                    nfill++;
                    chk({id, "_fill_addr"}, mem_addr, v.fill_addr);
                    pend = 1;
                end
            end else if (pend) begin
                pend = 0;
                mem_rdata_valid = 1'b1;
                mem_rdata = v.fill;
                rv_n = n;
            end
            @(negedge clk);
            n++;
        end
        mem_req_ready   = 1'b0;
        mem_rdata_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no response expected one", id);
        end
        chk({id, "_wb_count"}, nwb, v.exp_wb);
        chk({id, "_fill_count"}, nfill, v.exp_fill);
        chk({id, "_ready_back"}, req_ready, 1);
        chk({id, "_resp_once"}, resp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0]  = '{1'b0, 27'h0000014, 32'h0, L1,
                     1'b0, 27'h0, 128'h0, 1'b1, 27'h0000010, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 27'h0000014, 32'h0, L1,
                     1'b0, 27'h0, 128'h0, 1'b0, 27'h0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 27'h0000010, 32'h12345678, 128'h0,
                     1'b0, 27'h0, 128'h0, 1'b0, 27'h0, 32'h12345678};
        vecs[3]  = '{1'b0, 27'h0004010, 32'h0, L2,
                     1'b1, 27'h0000010, L1W, 1'b1, 27'h0004010, 32'hA0A0A0A0};
        vecs[4]  = '{1'b1, 27'h0008024, 32'hCAFEF00D, L3,
                     1'b0, 27'h0, 128'h0, 1'b1, 27'h0008020, 32'hCAFEF00D};
        vecs[5]  = '{1'b0, 27'h0008024, 32'h0, L3,
                     1'b0, 27'h0, 128'h0, 1'b0, 27'h0, 32'hCAFEF00D};
        vecs[6]  = '{1'b0, 27'h0008028, 32'h0, L3,
                     1'b0, 27'h0, 128'h0, 1'b0, 27'h0, 32'h30000002};
        vecs[7]  = '{1'b0, 27'h000C020, 32'h0, L4,
                     1'b1, 27'h0008020, L3W, 1'b1, 27'h000C020, 32'hC0000000};
        vecs[8]  = '{1'b0, 27'h0010030, 32'h0, L5,
                     1'b0, 27'h0, 128'h0, 1'b1, 27'h0010030, 32'h11111111};
        vecs[9]  = '{1'b0, 27'h0010034, 32'h0, L5,
                     1'b0, 27'h0, 128'h0, 1'b0, 27'h0, 32'h22222222};
        vecs[10] = '{1'b0, 27'h0010038, 32'h0, L5,
                     1'b0, 27'h0, 128'h0, 1'b0, 27'h0, 32'h33333333};
        vecs[11] = '{1'b0, 27'h001003C, 32'h0, L5,
                     1'b0, 27'h0, 128'h0, 1'b0, 27'h0, 32'h44444444};
        vecs[12] = '{1'b0, 27'h0010037, 32'h0, L5,
                     1'b0, 27'h0, 128'h0, 1'b0, 27'h0, 32'h22222222};
        vecs[13] = '{1'b1, 27'h0004018, 32'h55AA55AA, 128'h0,
                     1'b0, 27'h0, 128'h0, 1'b0, 27'h0, 32'h55AA55AA};

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
        #2;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Dirty victim at index 1 under held-off mem_req_ready.
        chk("bp_ready", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 27'h0000010;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_wb_valid", mem_req_valid, 1);
            chk("bp_wb_write", mem_write, 1);
            chk("bp_wb_addr", mem_addr, 27'h0004010);
            chk("bp_wb_data", mem_wdata, L2W);
            chk("bp_wb_req_ready", req_ready, 0);
            chk("bp_wb_resp", resp_valid, 0);
            @(negedge clk);
        end
        chk("bp_wb_valid_last", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_fill_valid", mem_req_valid, 1);
            chk("bp_fill_write", mem_write, 0);
            chk("bp_fill_addr", mem_addr, 27'h0000010);
            chk("bp_fill_req_ready", req_ready, 0);
            chk("bp_fill_resp", resp_valid, 0);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        mem_rdata_valid = 1'b1;
        mem_rdata = '1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rdata_valid = 1'b0;
        chk("bp_wait_no_req", mem_req_valid, 0);
        chk("bp_wait_no_resp", resp_valid, 0);
        mem_rdata_valid = 1'b1;
        mem_rdata = L6;
        @(negedge clk);
        mem_rdata_valid = 1'b0;
        @(negedge clk);
        chk("bp_resp_valid", resp_valid, 1);
        chk("bp_resp_rdata", resp_rdata, 32'h0BADF00D);
        @(negedge clk);
        v = '{1'b0, 27'h0000010, 32'h0, L6,
              1'b0, 27'h0, 128'h0, 1'b0, 27'h0, 32'h0BADF00D};
        run_vec(v, "bp_rehit");

        // Reset while waiting for fill data.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 27'h0050050;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rw_fill_req", mem_req_valid, 1);
        chk("rw_fill_addr", mem_addr, 27'h0050050);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rw_in_wait_ready", req_ready, 0);
        rst = 1'b1;
        #1;
        chk("rw_req_ready", req_ready, 1);
        chk("rw_resp_valid", resp_valid, 0);
        chk("rw_resp_rdata", resp_rdata, 0);
        chk("rw_mem_req_valid", mem_req_valid, 0);
        chk("rw_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_rdata_valid = 1'b1;
        mem_rdata = L7;
        @(negedge clk);
        mem_rdata_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rw_no_resp", resp_valid, 0);
            chk("rw_idle", req_ready, 1);
            chk("rw_no_mem", mem_req_valid, 0);
            @(negedge clk);
        end
        v = '{1'b0, 27'h0050050, 32'h0, L7,
              1'b0, 27'h0, 128'h0, 1'b1, 27'h0050050, 32'h7777AAAA};
        run_vec(v, "rw_reread");
        v = '{1'b0, 27'h0010034, 32'h0, L5,
              1'b0, 27'h0, 128'h0, 1'b1, 27'h0010030, 32'h22222222};
        run_vec(v, "rw_invalidated");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Write-back, write-allocate, direct-mapped cache controller between the CPU load/store port and the DDR2 memory interface. It owns the tag, valid, dirty and line-data arrays. It sequences every access through lookup, optional dirty-victim writeback, line fill and word merge, then returns a single-word response. One access is in flight at a time.

## Interface
- INDEX_BITS, 10, line index width; the cache holds 2^INDEX_BITS lines.
- Fixed, not parameters: 16-byte line (128 bits, four 32-bit words); address width 27; tag width = 27 − INDEX_BITS − 4 (13 at default).

Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  controller idle, request can be accepted
- req_write  in  1  1 = store, 0 = load
- req_addr  in  27  byte address; [3:2] word select, [1:0] ignored
- req_wdata  in  32  store data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load data, or the stored word on writes
- mem_req_valid  out  1  DDR2 line request
- mem_req_ready  in  1  DDR2 accepts request
- mem_write  out  1  1 = writeback, 0 = fill
- mem_addr  out  27  line address, [3:0] = 0
- mem_wdata  out  128  victim line (word 0 in [31:0])
- mem_rdata_valid  in  1  fill data present, one-cycle pulse
- mem_rdata  in  128  fill line

## Operation
- Address split: tag = addr[26:INDEX_BITS+4]; index = addr[INDEX_BITS+3:4]; word = addr[3:2].
- **IDLE**
  - req_ready=1.
  - On req_valid: latch the request, read the arrays at the index (registered read), go to LOOKUP.
- **LOOKUP**
  - Hit = valid[index] && tag match.
  - Read hit: resp_rdata = selected word.
  - Write hit: replace the word and set dirty.
  - On any hit go to RESP.
  - Miss with a valid, dirty victim: go to WB_REQ.
  - Any other miss: go to FILL_REQ.
- **WB_REQ**
  - mem_req_valid=1, mem_write=1, mem_addr={victim_tag,index,4'b0}, mem_wdata=victim line.
  - On mem_req_ready go to FILL_REQ.
- **FILL_REQ**
  - mem_req_valid=1, mem_write=0, mem_addr={req_tag,index,4'b0}.
  - On mem_req_ready go to FILL_WAIT.
- **FILL_WAIT**
  - On mem_rdata_valid go to REFILL.
- **REFILL**
  - Write the fill line and tag; set valid=1.
  - On a write, merge req_wdata into the word and set dirty=1; otherwise dirty=0.
  - Go to RESP.
- **RESP**
  - resp_valid=1 for exactly this cycle.
  - resp_rdata = final word value: the filled word on a read miss, req_wdata on any write.
  - Go to IDLE.
- mem_addr, mem_wdata and mem_write stay stable while mem_req_valid=1 and mem_req_ready=0.
- mem_rdata_valid is ignored outside FILL_WAIT.
- Request inputs are ignored unless req_ready=1.

## Timing
- Cycle 0 is the accept cycle (req_valid && req_ready).
- Hit: resp_valid in cycle 2; req_ready returns to 1 in cycle 3; no memory traffic.
- Clean miss: resp_valid 2 cycles after the cycle in which mem_rdata_valid is sampled (REFILL, then RESP).
- Dirty miss: the writeback handshake completes strictly before the fill request is asserted; never both in one cycle.
- Earliest fill: mem_rdata_valid in the cycle after the fill handshake.
- Reset values:
  - req_ready=1; resp_valid=0; resp_rdata=0.
  - mem_req_valid=0; mem_write=0; mem_addr=0; mem_wdata=0.
  - State IDLE; all valid and dirty bits cleared.
  - Tag and data arrays are not reset.
- Reset mid-operation (any state): the transaction is abandoned and outputs take reset values immediately. No response is ever issued for it. A late mem_rdata_valid is ignored.
- Same-cycle events: mem_req_ready with mem_rdata_valid in FILL_REQ means only the handshake counts; the data is ignored.

## Test plan
- **Read miss then hit:** after reset, read 0x0000014; fill returns word1=0xDEADBEEF.
  - Required: one fill at mem_addr 0x0000010 and resp_rdata=0xDEADBEEF.
  - Re-read of the same address: resp_valid in cycle 2 with no mem_req_valid.
- **Dirty eviction:** store 0x12345678 to 0x0000010 (a hit after the fill). Then read 0x0004010 (same index, different tag).
  - Required: writeback at 0x0000010 with mem_wdata[31:0]=0x12345678.
  - Then a fill at 0x0004010, then the response.
- **Write miss on a clean/invalid line:**
  - Required: fill only, with no writeback.
  - The merged word is returned on a later hit.
  - A later conflicting read writes back the merged line.
- **Backpressure:** hold mem_req_ready=0 for 5 cycles in WB_REQ and FILL_REQ.
  - Required: mem_req_valid, mem_addr and mem_wdata stable throughout; req_ready=0; no resp_valid.
- **Reset in FILL_WAIT:** assert rst while the controller waits for fill data.
  - Required: all outputs at reset values immediately.
  - A mem_rdata_valid pulse after reset is ignored.
  - A re-read of the same address misses.
- **Word select:** fill line {0x44444444,0x33333333,0x22222222,0x11111111}.
  - Required: reads at offsets 0x0, 0x4, 0x8 and 0xC return 0x11111111, 0x22222222, 0x33333333 and 0x44444444 respectively.
  - Required: offset 0x7 returns the same word as offset 0x4.
